// File: rtl/icache_direct_mapped_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   ICACHE_WORD_SIZE : default fetch word width
//   state_e          : controller state encoding (IDLE=0, FILL=1)
//   offset_w/index_w/tag_w : address field widths derived from geometry
package icache_direct_mapped_pkg;

  localparam int ICACHE_WORD_SIZE  = 16;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_NUM_LINES  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int word_size, input int line_words, input int num_lines);
    return word_size - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_direct_mapped_array.sv
// Tag / valid / data storage for the direct-mapped instruction cache.
//   clk_i, rst_i     : clock, asynchronous active-high reset (valid bits only)
//   clear_all_i      : invalidate every line at the next posedge
//   rd_index_i       : combinational read port -> rd_tag_o, rd_valid_o, rd_line_o
//   wr_en_i ...      : synchronous write port (index, tag, line, valid)
module icache_array
  import icache_direct_mapped_pkg::*;
#(
  parameter int WORD_SIZE  = ICACHE_WORD_SIZE,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES,
  parameter int INDEX_W    = index_w(NUM_LINES),
  parameter int TAG_W      = tag_w(WORD_SIZE, LINE_WORDS, NUM_LINES)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clear_all_i,
  input  logic [INDEX_W-1:0]                    rd_index_i,
  output logic [TAG_W-1:0]                      rd_tag_o,
  output logic                                  rd_valid_o,
  output logic [LINE_WORDS-1:0][WORD_SIZE-1:0]  rd_line_o,
  input  logic                                  wr_en_i,
  input  logic [INDEX_W-1:0]                    wr_index_i,
  input  logic [TAG_W-1:0]                      wr_tag_i,
  input  logic [LINE_WORDS-1:0][WORD_SIZE-1:0]  wr_line_i,
  input  logic                                  wr_valid_i
);

  logic [NUM_LINES-1:0]                 valid_q;
  logic [TAG_W-1:0]                     tag_q  [NUM_LINES];
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] data_q [NUM_LINES];

  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_line_o  = data_q[rd_index_i];

  // A clear in the same cycle as a write leaves the written line invalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      if (clear_all_i) begin
        valid_q <= '0;
      end else if (wr_en_i) begin
        valid_q[wr_index_i] <= wr_valid_i;
      end
    end
  end

  // Tag and data contents are qualified by valid, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_line_i;
    end
  end

endmodule

// File: rtl/icache_direct_mapped.sv
// Blocking direct-mapped instruction cache between the datapath fetch port
// and backing memory.
//   Clk, Reset            : clock, asynchronous active-high reset
//   readM1, address1      : fetch request and word address
//   data1, M1busy         : fetched word (hit, same cycle) / stall indication
//   flush                 : invalidate all lines
//   mem_read, mem_address : line fill request, line-aligned address
//   mem_valid, mem_rdata  : one-cycle fill response, word 0 in LSBs
//   num_hit, num_miss     : saturating statistics counters
//   dbg_state_o           : controller state (0 = IDLE, 1 = FILL)
// Handshake: a fill request is raised by mem_read and held with a stable
// mem_address until a single-cycle mem_valid pulse delivers the line; the
// datapath sees M1busy=1 for every requested cycle without valid data1.
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
#(
  parameter int WORD_SIZE  = ICACHE_WORD_SIZE,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            readM1,
  input  logic [WORD_SIZE-1:0]            address1,
  output logic [WORD_SIZE-1:0]            data1,
  output logic                            M1busy,
  input  logic                            flush,
  output logic                            mem_read,
  output logic [WORD_SIZE-1:0]            mem_address,
  input  logic                            mem_valid,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0]            num_hit,
  output logic [WORD_SIZE-1:0]            num_miss,
  output logic                            dbg_state_o
);

  localparam int OFFSET_W = offset_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(NUM_LINES);
  localparam int TAG_W    = tag_w(WORD_SIZE, LINE_WORDS, NUM_LINES);

  state_e                 state_q, state_d;
  logic                   mem_read_q, mem_read_d;
  logic [WORD_SIZE-1:0]   mem_address_q, mem_address_d;
  logic                   flush_seen_q, flush_seen_d;
  logic [WORD_SIZE-1:0]   num_hit_q, num_miss_q;

  logic [OFFSET_W-1:0]    req_offset;
  logic [INDEX_W-1:0]     req_index;
  logic [TAG_W-1:0]       req_tag;
  logic [TAG_W-1:0]       rd_tag;
  logic                   rd_valid;
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] rd_line;
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] fill_line;
  logic                   hit;
  logic                   wr_en, wr_valid;
  logic                   hit_inc, miss_inc;

  assign req_offset = address1[OFFSET_W-1:0];
  assign req_index  = address1[OFFSET_W +: INDEX_W];
  assign req_tag    = address1[WORD_SIZE-1 -: TAG_W];
  assign fill_line  = mem_rdata;

  // The fill target comes from the latched line address, so a redirected
  // address1 during FILL does not disturb where the line lands.
  icache_array #(
    .WORD_SIZE  (WORD_SIZE),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES),
    .INDEX_W    (INDEX_W),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .clear_all_i (flush),
    .rd_index_i  (req_index),
    .rd_tag_o    (rd_tag),
    .rd_valid_o  (rd_valid),
    .rd_line_o   (rd_line),
    .wr_en_i     (wr_en),
    .wr_index_i  (mem_address_q[OFFSET_W +: INDEX_W]),
    .wr_tag_i    (mem_address_q[WORD_SIZE-1 -: TAG_W]),
    .wr_line_i   (fill_line),
    .wr_valid_i  (wr_valid)
  );

  assign hit = rd_valid && (rd_tag == req_tag);

  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_address_d = mem_address_q;
    flush_seen_d  = flush_seen_q;
    wr_en         = 1'b0;
    wr_valid      = 1'b0;
    data1         = '0;
    M1busy        = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        flush_seen_d = 1'b0;
        if (readM1) begin
          if (hit) begin
            data1   = rd_line[req_offset];
            hit_inc = 1'b1;
          end else begin
            M1busy   = 1'b1;
            miss_inc = 1'b1;
            // A flush this cycle wins; the miss is retried next cycle.
            if (!flush) begin
              state_d       = ST_FILL;
              mem_read_d    = 1'b1;
              mem_address_d = {address1[WORD_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
          end
        end
      end
      ST_FILL: begin
        M1busy = readM1;
        if (flush) begin
          flush_seen_d = 1'b1;
        end
        if (mem_valid) begin
          wr_en        = 1'b1;
          wr_valid     = !(flush_seen_q || flush);
          mem_read_d   = 1'b0;
          flush_seen_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // While reset is held the fetch port reports stall with no data.
    if (Reset) begin
      data1    = '0;
      M1busy   = readM1;
      hit_inc  = 1'b0;
      miss_inc = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      flush_seen_q  <= 1'b0;
      num_hit_q     <= '0;
      num_miss_q    <= '0;
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      flush_seen_q  <= flush_seen_d;
      if (hit_inc && (num_hit_q != '1)) begin
        num_hit_q <= num_hit_q + 1'b1;
      end
      if (miss_inc && (num_miss_q != '1)) begin
        num_miss_q <= num_miss_q + 1'b1;
      end
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;
  assign num_hit     = num_hit_q;
  assign num_miss    = num_miss_q;
  assign dbg_state_o = state_q;

endmodule
